// File: rtl/snake_pkg.sv
// ---------------------------------------------------------------------------
// snake_pkg
// Shared definitions for the snake playfield logic.
//   - GRID_W_DEF / GRID_H_DEF : default playfield size in cells
//   - MAX_RETRY_DEF           : default random-candidate budget of food_placer
//   - xcoord_t / ycoord_t     : cell coordinate types (8 b / 7 b)
//   - fp_state_t              : food_placer FSM state encoding
//   - cell_in_range()         : legal-cell check (x in 1..W-1, y in 1..H-1)
// Optional feature macro: FOOD_FALLBACK_SCAN_EN adds the ST_SCAN state.
// ---------------------------------------------------------------------------
package snake_pkg;

    localparam int GRID_W_DEF    = 160;
    localparam int GRID_H_DEF    = 120;
    localparam int MAX_RETRY_DEF = 16;

    typedef logic [7:0] xcoord_t;
    typedef logic [6:0] ycoord_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_QUERY,
        ST_WAIT,
        ST_COMMIT
`ifdef FOOD_FALLBACK_SCAN_EN
        ,
        ST_SCAN
`endif
    } fp_state_t;

    // Row/column 0 is the border, so a legal cell is strictly inside.
    // Both axes are compared as 8-bit unsigned values.
    function automatic logic cell_in_range(xcoord_t x, ycoord_t y,
                                           int grid_w, int grid_h);
        logic [7:0] y8;
        y8 = {1'b0, y};
        return (x != 8'd0) && (x < 8'(grid_w)) &&
               (y8 != 8'd0) && (y8 < 8'(grid_h));
    endfunction

endpackage

// File: rtl/food_placer_if.sv
// ---------------------------------------------------------------------------
// food_placer_if
// Occupancy-lookup handshake between food_placer (master) and the snake-body
// occupancy logic (slave).
//   occ_req        master->slave  single-cycle query strobe
//   occ_x / occ_y  master->slave  queried cell, valid with occ_req
//   occ_resp_valid slave->master  response strobe, >=1 cycle after occ_req
//   occ_hit        slave->master  1 = cell occupied, valid with occ_resp_valid
// ---------------------------------------------------------------------------
interface food_placer_if;

    logic              occ_req;
    snake_pkg::xcoord_t occ_x;
    snake_pkg::ycoord_t occ_y;
    logic              occ_resp_valid;
    logic              occ_hit;

    modport master (
        output occ_req,
        output occ_x,
        output occ_y,
        input  occ_resp_valid,
        input  occ_hit
    );

    modport slave (
        input  occ_req,
        input  occ_x,
        input  occ_y,
        output occ_resp_valid,
        output occ_hit
    );

endinterface

// File: rtl/food_scan_step.sv
// ---------------------------------------------------------------------------
// food_scan_step
// Combinational next-cell generator for the raster fallback scan.
//   i_x, i_y   : current cell
//   i_restart  : current cell was not a legal cell -> restart at (1,1)
//   o_x, o_y   : next cell in raster order over the legal area, wrapping
//                x back to 1 with y+1, and y back to 1 past the last row
// ---------------------------------------------------------------------------
module food_scan_step
    import snake_pkg::*;
#(
    parameter int GRID_W = GRID_W_DEF,
    parameter int GRID_H = GRID_H_DEF
) (
    input  xcoord_t i_x,
    input  ycoord_t i_y,
    input  logic    i_restart,
    output xcoord_t o_x,
    output ycoord_t o_y
);

    // One extra bit so x = 255 / y = 127 cannot wrap before the compare.
    logic [8:0] w_x_inc;
    logic [7:0] w_y_inc;

    assign w_x_inc = {1'b0, i_x} + 9'd1;
    assign w_y_inc = {1'b0, i_y} + 8'd1;

    always_comb begin
        o_x = w_x_inc[7:0];
        o_y = i_y;
        if (i_restart) begin
            o_x = 8'd1;
            o_y = 7'd1;
        end else if (w_x_inc >= 9'(GRID_W)) begin
            o_x = 8'd1;
            o_y = (w_y_inc >= 8'(GRID_H)) ? 7'd1 : w_y_inc[6:0];
        end
    end

endmodule

// File: rtl/food_placer.sv
// ---------------------------------------------------------------------------
// food_placer
// Places a new food item on the snake playfield. On a request it samples the
// free-running RNG, range-checks the candidate, asks the occupancy logic
// whether the cell is free and resamples until a free cell is found or the
// retry budget is spent.
//
// Ports
//   clk, rst_n      : clock, synchronous active-low reset
//   i_place_req     : single-cycle placement request (ignored while busy)
//   i_rng_pos_x/y   : RNG candidate cell
//   occ             : occupancy query handshake (food_placer_if.master)
//   o_food_x/y      : current food cell
//   o_food_valid    : food cell is valid
//   o_busy          : placement in progress
//   o_place_fail    : single-cycle pulse, no free cell found
//
// Optional feature macro: FOOD_FALLBACK_SCAN_EN
//   defined   : on retry exhaustion, raster-scan the playfield from the last
//               candidate and commit the first free cell; fail only after
//               every legal cell has been queried
//   undefined : retry exhaustion pulses o_place_fail directly
// ---------------------------------------------------------------------------
module food_placer
    import snake_pkg::*;
#(
    parameter int GRID_W    = GRID_W_DEF,
    parameter int GRID_H    = GRID_H_DEF,
    parameter int MAX_RETRY = MAX_RETRY_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_place_req,
    input  xcoord_t       i_rng_pos_x,
    input  ycoord_t       i_rng_pos_y,
    food_placer_if.master occ,
    output xcoord_t       o_food_x,
    output ycoord_t       o_food_y,
    output logic          o_food_valid,
    output logic          o_busy,
    output logic          o_place_fail
);

    localparam int                 RETRY_W   = $clog2(MAX_RETRY + 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    fp_state_t          r_state;
    fp_state_t          w_state_next;

    xcoord_t            r_cand_x;
    ycoord_t            r_cand_y;
    logic [RETRY_W-1:0] r_retry;
    logic [RETRY_W-1:0] w_retry_inc;
    xcoord_t            r_food_x;
    ycoord_t            r_food_y;
    logic               r_food_valid;
    logic               r_busy;
    logic               r_place_fail;

    logic               w_rng_ok;
    logic               w_retry_last;
    logic               w_resp_free;
    logic               w_resp_hit;
    logic               w_fail;
    logic               w_occ_req;

    xcoord_t            w_step_x;
    ycoord_t            w_step_y;
    logic               w_step_restart;

    assign w_rng_ok     = cell_in_range(i_rng_pos_x, i_rng_pos_y, GRID_W, GRID_H);
    // Saturating increment: the counter parks at MAX_RETRY and never wraps.
    assign w_retry_inc  = (r_retry == RETRY_MAX) ? r_retry : r_retry + RETRY_W'(1);
    // This reject is the one that spends the last retry.
    assign w_retry_last = (w_retry_inc == RETRY_MAX);
    assign w_resp_free  = occ.occ_resp_valid && !occ.occ_hit;
    assign w_resp_hit   = occ.occ_resp_valid &&  occ.occ_hit;

`ifdef FOOD_FALLBACK_SCAN_EN
    localparam int SCAN_LIMIT = (GRID_W - 1) * (GRID_H - 1);
    localparam int SCAN_W     = $clog2(SCAN_LIMIT + 1);

    logic              r_scanning;
    logic              r_cand_oor;
    logic [SCAN_W-1:0] r_scan_cnt;
    logic              w_scan_done;

    // r_scan_cnt counts cells already issued by the scan; once every legal
    // cell has been tried and the last one is also occupied, give up.
    assign w_scan_done    = (r_scan_cnt == SCAN_W'(SCAN_LIMIT));
    assign w_step_restart = r_cand_oor;
`else
    assign w_step_restart = 1'b0;
`endif

    food_scan_step #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H)
    ) u_scan_step (
        .i_x       (r_cand_x),
        .i_y       (r_cand_y),
        .i_restart (w_step_restart),
        .o_x       (w_step_x),
        .o_y       (w_step_y)
    );

`ifndef FOOD_FALLBACK_SCAN_EN
    // Without the scan the step result has no consumer.
    logic w_unused_scan;
    assign w_unused_scan = ^{w_step_x, w_step_y};
`endif

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_state_next = r_state;
        w_fail       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_place_req) begin
                    w_state_next = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (w_rng_ok) begin
                    w_state_next = ST_QUERY;
                end else if (w_retry_last) begin
`ifdef FOOD_FALLBACK_SCAN_EN
                    w_state_next = ST_SCAN;
`else
                    w_state_next = ST_IDLE;
                    w_fail       = 1'b1;
`endif
                end
            end
            ST_QUERY: begin
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_resp_free) begin
                    w_state_next = ST_COMMIT;
                end else if (w_resp_hit) begin
`ifdef FOOD_FALLBACK_SCAN_EN
                    if (r_scanning) begin
                        if (w_scan_done) begin
                            w_state_next = ST_IDLE;
                            w_fail       = 1'b1;
                        end else begin
                            w_state_next = ST_SCAN;
                        end
                    end else if (w_retry_last) begin
                        w_state_next = ST_SCAN;
                    end else begin
                        w_state_next = ST_SAMPLE;
                    end
`else
                    if (w_retry_last) begin
                        w_state_next = ST_IDLE;
                        w_fail       = 1'b1;
                    end else begin
                        w_state_next = ST_SAMPLE;
                    end
`endif
                end
            end
            ST_COMMIT: begin
                w_state_next = ST_IDLE;
            end
`ifdef FOOD_FALLBACK_SCAN_EN
            ST_SCAN: begin
                w_state_next = ST_QUERY;
            end
`endif
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // --------------------------------------------------------------- outputs
    always_comb begin
        w_occ_req = 1'b0;
        if (r_state == ST_QUERY) begin
            w_occ_req = 1'b1;
        end
    end

    // -------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cand_x     <= '0;
            r_cand_y     <= '0;
            r_retry      <= '0;
            r_food_x     <= '0;
            r_food_y     <= '0;
            r_food_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_place_fail <= 1'b0;
        end else begin
            r_place_fail <= w_fail;
            if (w_fail) begin
                r_busy <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (i_place_req) begin
                        r_food_valid <= 1'b0;
                        r_busy       <= 1'b1;
                        r_retry      <= '0;
                    end
                end
                ST_SAMPLE: begin
                    // Captured even when out of range: the scan restarts
                    // from it (or from (1,1) if it was illegal).
                    r_cand_x <= i_rng_pos_x;
                    r_cand_y <= i_rng_pos_y;
                    if (!w_rng_ok) begin
                        r_retry <= w_retry_inc;
                    end
                end
                ST_WAIT: begin
                    if (w_resp_hit) begin
                        r_retry <= w_retry_inc;
                    end
                end
                ST_COMMIT: begin
                    r_food_x     <= r_cand_x;
                    r_food_y     <= r_cand_y;
                    r_food_valid <= 1'b1;
                    r_busy       <= 1'b0;
                end
`ifdef FOOD_FALLBACK_SCAN_EN
                ST_SCAN: begin
                    r_cand_x <= w_step_x;
                    r_cand_y <= w_step_y;
                end
`endif
                default: begin
                end
            endcase
        end
    end

`ifdef FOOD_FALLBACK_SCAN_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_scanning <= 1'b0;
            r_cand_oor <= 1'b0;
            r_scan_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_place_req) begin
                        r_scanning <= 1'b0;
                        r_scan_cnt <= '0;
                    end
                end
                ST_SAMPLE: begin
                    r_cand_oor <= !w_rng_ok;
                end
                ST_SCAN: begin
                    r_scanning <= 1'b1;
                    r_cand_oor <= 1'b0;
                    r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
                end
                default: begin
                end
            endcase
        end
    end
`endif

    assign occ.occ_req   = w_occ_req;
    assign occ.occ_x     = r_cand_x;
    assign occ.occ_y     = r_cand_y;
    assign o_food_x      = r_food_x;
    assign o_food_y      = r_food_y;
    assign o_food_valid  = r_food_valid;
    assign o_busy        = r_busy;
    assign o_place_fail  = r_place_fail;

endmodule
